// File: rtl/row_result_streamer_pkg.sv
// Shared parameters and state encoding for the row result streamer.
package row_result_streamer_pkg;

    localparam int ACCUMULATOR_SIZE = 32;
    localparam int ROW_ID_SIZE      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/row_result_streamer_fifo.sv
// Two-entry FIFO holding row sums (with their index) between the RAM
// read port and the stream output.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                wp <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/row_result_streamer.sv
// Drains the row accumulator RAM into the argmax tracker and latches the
// winning row index at the end of the pass.
module row_result_streamer
    import row_result_streamer_pkg::*;
#(
    parameter int ACC_W = ACCUMULATOR_SIZE,
    parameter int ROW_W = ROW_ID_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ROW_W:0]          num_rows,
    output logic                    rd_en,
    output logic [ROW_W-1:0]        rd_addr,
    input  logic [ACC_W-1:0]        rd_data,
    output logic                    tracker_clr,
    output logic                    stream_valid,
    input  logic                    stream_ready,
    output logic signed [ACC_W-1:0] stream,
    output logic [ROW_W-1:0]        index,
    input  logic [ROW_W-1:0]        max_index,
    output logic                    busy,
    output logic                    done,
    output logic [ROW_W-1:0]        result_index
);

    state_t                   state;
    state_t                   state_nx;
    logic [ROW_W:0]           cnt;
    logic [ROW_W:0]           addr;
    logic [ROW_W:0]           sent;
    logic                     inflight;
    logic [ROW_W-1:0]         addr_q;
    logic [1:0]               occ;
    logic [ACC_W+ROW_W-1:0]   head;
    logic                     issue;
    logic                     pop;
    logic                     credit;

    skid_fifo2 #(
        .W(ACC_W + ROW_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data({addr_q, rd_data}),
        .pop      (pop),
        .head     (head),
        .occ      (occ)
    );

    // A read is only launched if its data is sure to find a free slot.
    assign credit = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign issue  = (state == ST_RUN) && (addr < cnt) && credit;

    assign stream_valid = !rst && (occ != 2'd0);
    assign pop          = stream_valid && stream_ready;
    assign stream       = stream_valid ? head[ACC_W-1:0] : '0;
    assign index        = stream_valid ? head[ACC_W +: ROW_W] : '0;
    assign rd_en        = !rst && issue;
    assign rd_addr      = rd_en ? addr[ROW_W-1:0] : '0;
    assign tracker_clr  = !rst && (state == ST_CLR);
    assign busy         = !rst && (state != ST_IDLE);
    assign done         = !rst && (state == ST_DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_CLR;
            ST_CLR:  state_nx = (cnt == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (pop && (sent + 1'b1 == cnt)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            addr         <= '0;
            sent         <= '0;
            inflight     <= 1'b0;
            addr_q       <= '0;
            result_index <= '0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (issue) begin
                addr   <= addr + 1'b1;
                addr_q <= addr[ROW_W-1:0];
            end
            if ((state == ST_IDLE) && start) begin
                cnt  <= num_rows;
                addr <= '0;
                sent <= '0;
            end
            if (pop) begin
                sent <= sent + 1'b1;
            end
            if (state == ST_DONE) begin
                result_index <= max_index;
            end
        end
    end

endmodule

// File: tb/tb_row_result_streamer.sv
// Randomised self-checking bench for row_result_streamer with a RAM model
// and a behavioural argmax tracker attached.
module tb_row_result_streamer;

    localparam int ACC_W = 32;
    localparam int ROW_W = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [ROW_W:0]          num_rows = '0;
    logic                    rd_en;
    logic [ROW_W-1:0]        rd_addr;
    logic signed [ACC_W-1:0] rd_data = '0;
    logic                    tracker_clr;
    logic                    stream_valid;
    logic                    stream_ready = 1'b1;
    logic signed [ACC_W-1:0] stream;
    logic [ROW_W-1:0]        index;
    logic [ROW_W-1:0]        max_index = '0;
    logic                    busy;
    logic                    done;
    logic [ROW_W-1:0]        result_index;

    int checks = 0;
    int errors = 0;
    bit rnd_ready = 1'b0;

    logic signed [ACC_W-1:0] ram [16];

    row_result_streamer #(.ACC_W(ACC_W), .ROW_W(ROW_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_rows    (num_rows),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tracker_clr (tracker_clr),
        .stream_valid(stream_valid),
        .stream_ready(stream_ready),
        .stream      (stream),
        .index       (index),
        .max_index   (max_index),
        .busy        (busy),
        .done        (done),
        .result_index(result_index)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= ram[rd_addr];
    end

    // Argmax tracker: first strictly greater value wins.
    logic                    trk_has = 1'b0;
    logic signed [ACC_W-1:0] trk_max = '0;
    initial forever begin
        @(posedge clk);
        if (rst || tracker_clr) begin
            trk_has   <= 1'b0;
            trk_max   <= '0;
            max_index <= '0;
        end else if (stream_valid && stream_ready &&
                     (!trk_has || stream > trk_max)) begin
            trk_has   <= 1'b1;
            trk_max   <= stream;
            max_index <= index;
        end
    end

    initial forever begin
        @(negedge clk);
        stream_ready = rnd_ready ? ($urandom_range(99) >= 40) : 1'b1;
    end

    int rel = 0;
    int clr_cyc = -1;
    int rd_first = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int rd_cnt = 0;
    int valid_cnt = 0;
    int stab_viol = 0;
    int occ_viol = 0;
    int m_occ = 0;
    bit m_infl = 1'b0;
    bit hold = 1'b0;
    bit xfer;
    logic signed [ACC_W-1:0] h_dat;
    logic [ROW_W-1:0]        h_idx;
    int                      xfer_idx [$];
    logic signed [ACC_W-1:0] xfer_dat [$];
    int                      xfer_cyc [$];

    // rel = cycle number (start sampled at the end of cycle 0)
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_occ  = 0;
            m_infl = 1'b0;
            hold   = 1'b0;
            rel    = rel + 1;
        end else begin
            if (start && !busy) begin
                rel = 0; clr_cyc = -1; rd_first = -1; done_cyc = -1;
                done_cnt = 0; rd_cnt = 0; valid_cnt = 0;
                xfer_idx.delete(); xfer_dat.delete(); xfer_cyc.delete();
            end else begin
                rel = rel + 1;
            end
            if (tracker_clr && clr_cyc < 0) clr_cyc = rel;
            if (rd_en) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = rel;
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (stream_valid) valid_cnt++;
            if (hold && (!stream_valid || stream !== h_dat || index !== h_idx))
                stab_viol++;
            xfer = stream_valid && stream_ready;
            if (xfer) begin
                xfer_idx.push_back(int'(index));
                xfer_dat.push_back(stream);
                xfer_cyc.push_back(rel);
            end
            hold  = stream_valid && !stream_ready;
            h_dat = stream;
            h_idx = index;
            if (stream_valid !== (m_occ != 0)) occ_viol++;
            m_occ = m_occ + int'(m_infl) - int'(xfer);
            if (m_occ > 2 || m_occ < 0) occ_viol++;
            m_infl = rd_en;
        end
    end

    function automatic int argmax(input int n);
        int b = 0;
        for (int k = 1; k < n; k++)
            if (ram[k] > ram[b]) b = k;
        return b;
    endfunction

    function automatic int order_errs(input int n);
        int bad = 0;
        for (int k = 0; k < xfer_idx.size(); k++)
            if (k >= n || xfer_idx[k] != k || xfer_dat[k] !== ram[k]) bad++;
        return bad;
    endfunction

    task automatic run_pass(input int n);
        int t = 0;
        @(negedge clk);
        num_rows = n[ROW_W:0];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL pass_timeout n=%0d got no done want done", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en, tracker_clr, stream_valid, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {rd_en, tracker_clr, stream_valid, busy, done});
        end
        checks++;
        if (stream !== '0 || index !== '0 || rd_addr !== '0 ||
            result_index !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0",
                     stream, index, rd_addr, result_index);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_ramp();
        int bad = 0;
        logic [ROW_W-1:0] e;
        rnd_ready = 1'b0;
        for (int k = 0; k < 16; k++) ram[k] = k * 3 - 20;
        run_pass(16);
        checks++;
        if (clr_cyc != 1 || rd_first != 2 || done_cyc != 20) begin
            errors++;
            $display("FAIL ramp_timing got clr=%0d rd=%0d done=%0d want 1 2 20",
                     clr_cyc, rd_first, done_cyc);
        end
        for (int k = 0; k < xfer_cyc.size(); k++)
            if (xfer_cyc[k] != 4 + k) bad++;
        bad += order_errs(16);
        checks++;
        if (xfer_idx.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL ramp_stream got n=%0d bad=%0d want n=16 bad=0",
                     xfer_idx.size(), bad);
        end
        e = ROW_W'(argmax(16));
        checks++;
        if (result_index !== e || rd_cnt != 16) begin
            errors++;
            $display("FAIL ramp_result got idx=%0d rd=%0d want idx=%0d rd=16",
                     result_index, rd_cnt, e);
        end
    endtask

    task automatic test_big_row();
        logic [ROW_W-1:0] e;
        for (int k = 0; k < 16; k++) ram[k] = $urandom_range(2000) - 1000;
        ram[9] = 32'h7FFF_FFF0;
        run_pass(16);
        e = ROW_W'(argmax(16));
        checks++;
        if (result_index !== e || order_errs(16) != 0) begin
            errors++;
            $display("FAIL big_row got idx=%0d want idx=%0d", result_index, e);
        end
    endtask

    task automatic test_negative();
        logic [ROW_W-1:0] e;
        for (int k = 0; k < 16; k++) ram[k] = -100 - k;
        run_pass(16);
        e = ROW_W'(argmax(16));
        checks++;
        if (result_index !== e) begin
            errors++;
            $display("FAIL negative got idx=%0d want idx=%0d", result_index, e);
        end
    endtask

    task automatic test_random_ready();
        logic [ROW_W-1:0] e;
        int bad;
        for (int k = 0; k < 16; k++) ram[k] = $urandom;
        stab_viol = 0;
        occ_viol  = 0;
        rnd_ready = 1'b1;
        run_pass(16);
        rnd_ready = 1'b0;
        bad = order_errs(16);
        checks++;
        if (xfer_idx.size() != 16 || bad != 0 || rd_cnt != 16) begin
            errors++;
            $display("FAIL rnd_stream got n=%0d bad=%0d rd=%0d want 16 0 16",
                     xfer_idx.size(), bad, rd_cnt);
        end
        checks++;
        if (stab_viol != 0 || occ_viol != 0) begin
            errors++;
            $display("FAIL rnd_flow got stab=%0d occ=%0d want 0 0",
                     stab_viol, occ_viol);
        end
        e = ROW_W'(argmax(16));
        checks++;
        if (result_index !== e) begin
            errors++;
            $display("FAIL rnd_result got idx=%0d want idx=%0d", result_index, e);
        end
    endtask

    task automatic test_zero_rows();
        run_pass(0);
        checks++;
        if (rd_cnt != 0 || valid_cnt != 0 || clr_cyc != 1 || done_cyc != 2) begin
            errors++;
            $display("FAIL zero_rows got rd=%0d v=%0d clr=%0d done=%0d want 0 0 1 2",
                     rd_cnt, valid_cnt, clr_cyc, done_cyc);
        end
    endtask

    task automatic test_start_in_run();
        int t = 0;
        logic [ROW_W-1:0] e;
        for (int k = 0; k < 16; k++) ram[k] = $urandom;
        rnd_ready = 1'b1;
        @(negedge clk);
        num_rows = 5'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
            if (t == 6) begin
                num_rows = 5'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) @(negedge clk);
        e = ROW_W'(argmax(8));
        checks++;
        if (xfer_idx.size() != 8 || order_errs(8) != 0 || done_cnt != 1 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run got n=%0d done=%0d busy=%b want 8 1 0",
                     xfer_idx.size(), done_cnt, busy);
        end
        checks++;
        if (result_index !== e) begin
            errors++;
            $display("FAIL start_in_run_idx got %0d want %0d", result_index, e);
        end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int snap;
        logic [ROW_W-1:0] e;
        for (int k = 0; k < 16; k++) ram[k] = $urandom_range(500);
        @(negedge clk);
        num_rows = 5'd16;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rel < 7 && t < 50) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_en, tracker_clr, stream_valid, busy, done} !== 5'b0 ||
            stream !== '0 || index !== '0 || result_index !== '0) begin
            errors++;
            $display("FAIL mid_reset got ctrl=%b s=%h i=%h r=%h want 0",
                     {rd_en, tracker_clr, stream_valid, busy, done},
                     stream, index, result_index);
        end
        snap = rd_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (rd_cnt != snap || stream_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet got rd=%0d v=%b want rd=%0d v=0",
                     rd_cnt, stream_valid, snap);
        end
        run_pass(4);
        e = ROW_W'(argmax(4));
        checks++;
        if (done_cyc != 8 || xfer_idx.size() != 4 || order_errs(4) != 0 ||
            result_index !== e) begin
            errors++;
            $display("FAIL restart got done=%0d n=%0d idx=%0d want 8 4 %0d",
                     done_cyc, xfer_idx.size(), result_index, e);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_big_row();
        test_negative();
        test_random_ready();
        test_zero_rows();
        test_start_in_run();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
